// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential shift-and-add-3 binary-to-BCD converter, one bit per
//            clock, start/busy/done handshake, saturating overflow.
//            Optional leading-zero blank mask: define LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               state, state_next;
  logic [BIN_W-1:0]     binreg;
  logic [4*DIGITS-1:0]  scratch;
  logic [4*DIGITS-1:0]  shifted;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_flag;
  logic                 ovf_cap;
  logic                 load;
  logic                 last;
  logic [3:0]           digit;
  logic                 carry;

  assign ovf_cap = ({{(64-BIN_W){1'b0}}, bin} > MAX_VAL);
  assign load    = (state == IDLE) && start;
  assign last    = (state == SHIFT) && (cnt == CNT_ONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_ONE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Per-digit add-3 then a one-bit left shift; each digit's old MSB carries
  // into the next digit's LSB, the binary MSB feeds digit 0.
  always_comb begin
    shifted = '0;
    digit   = '0;
    carry   = binreg[BIN_W-1];
    for (int i = 0; i < DIGITS; i++) begin
      digit = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                          : scratch[4*i +: 4];
      shifted[4*i +: 4] = {digit[2:0], carry};
      carry = digit[3];
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      binreg   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        binreg   <= bin;
        scratch  <= '0;
        cnt      <= CNT_LOAD;
        ovf_flag <= ovf_cap;
        busy     <= 1'b1;
      end else if (state == SHIFT) begin
        scratch <= shifted;
        binreg  <= {binreg[BIN_W-2:0], 1'b0};
        cnt     <= cnt - CNT_ONE;
        if (last) begin
          bcd  <= ovf_flag ? ALL_NINES : shifted;
          ovf  <= ovf_flag;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              zero_run;

  // Digit 0 is never blanked so a zero value still shows one "0".
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run && (shifted[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset)    blank <= '0;
    else if (last) blank <= ovf_flag ? '0 : blank_next;
  end
`else
  assign blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Directed table-driven bench for bin2bcd_seq plus handshake,
//            back-to-back and mid-conversion reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;
  logic [7:0]  blank;

  int n_vec  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .ovf       (ovf),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  blank;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (done) found = 1'b1;
    end
    if (!found) begin
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", cycles);
    end
  endtask

  task automatic run_conv(input vec_t v, input string name);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    bin   = v.bin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({name, "_lat"},   32'(lat), 32'd27);
    check({name, "_bcd"},   bcd, v.bcd);
    check({name, "_ovf"},   32'(ovf), 32'(v.ovf));
    check({name, "_blank"}, 32'(blank), BLANK_ON ? 32'(v.blank) : 32'd0);
    held = bcd;
    @(posedge clk); #1;
    check({name, "_donelow"}, {30'd0, done, busy}, 32'd0);
    check({name, "_held"}, bcd, held);
  endtask

  initial begin
    int lat;
    int seen;
    vecs[0]  = '{bin: 27'd0,         bcd: 32'h00000000, ovf: 1'b0, blank: 8'hFE};
    vecs[1]  = '{bin: 27'd12345678,  bcd: 32'h12345678, ovf: 1'b0, blank: 8'h00};
    vecs[2]  = '{bin: 27'd99999999,  bcd: 32'h99999999, ovf: 1'b0, blank: 8'h00};
    vecs[3]  = '{bin: 27'd100000000, bcd: 32'h99999999, ovf: 1'b1, blank: 8'h00};
    vecs[4]  = '{bin: 27'd134217727, bcd: 32'h99999999, ovf: 1'b1, blank: 8'h00};
    vecs[5]  = '{bin: 27'd5,         bcd: 32'h00000005, ovf: 1'b0, blank: 8'hFE};
    vecs[6]  = '{bin: 27'd9,         bcd: 32'h00000009, ovf: 1'b0, blank: 8'hFE};
    vecs[7]  = '{bin: 27'd10,        bcd: 32'h00000010, ovf: 1'b0, blank: 8'hFC};
    vecs[8]  = '{bin: 27'd99,        bcd: 32'h00000099, ovf: 1'b0, blank: 8'hFC};
    vecs[9]  = '{bin: 27'd305,       bcd: 32'h00000305, ovf: 1'b0, blank: 8'hF8};
    vecs[10] = '{bin: 27'd10000000,  bcd: 32'h10000000, ovf: 1'b0, blank: 8'h00};
    vecs[11] = '{bin: 27'd42,        bcd: 32'h00000042, ovf: 1'b0, blank: 8'hFC};

    reset = 1'b0;
    start = 1'b0;
    bin   = '0;
    #100;
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_bcd", bcd, 32'd0);
    check("rst_ovf_blank", {23'd0, ovf, blank}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_conv(vecs[i], $sformatf("vec%0d", i));

    // Second start at cycle 10 is ignored; bin also changes freely while busy.
    @(negedge clk);
    bin = 27'd305; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = 27'd7;
    repeat (9) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 32'(lat + 10), 32'd27);
    check("ign_bcd", bcd, 32'h00000305);
    check("ign_blank", 32'(blank), BLANK_ON ? 32'hF8 : 32'h0);
    @(posedge clk); #1;
    check("ign_idle", {30'd0, busy, done}, 32'd0);

    // Back-to-back with start held high: captures in the done cycle.
    @(negedge clk);
    bin = 27'd42; start = 1'b1;
    @(posedge clk); #1;
    bin = 27'd43;
    wait_done(lat);
    check("b2b_lat0", 32'(lat), 32'd27);
    check("b2b_bcd0", bcd, 32'h00000042);
    wait_done(lat);
    start = 1'b0;
    check("b2b_lat1", 32'(lat), 32'd28);
    check("b2b_bcd1", bcd, 32'h00000043);
    @(posedge clk); #1;
    check("b2b_noretrig", {30'd0, busy, done}, 32'd0);

    // Reset at cycle 12 of a conversion discards it with no done pulse.
    @(negedge clk);
    bin = 27'd87654321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    check("mrst_busy_done", {30'd0, busy, done}, 32'd0);
    check("mrst_bcd", bcd, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("mrst_quiet", 32'(seen), 32'd0);
    check("mrst_bcd_hold", bcd, 32'd0);
    run_conv('{bin: 27'd87654321, bcd: 32'h87654321, ovf: 1'b0, blank: 8'h00}, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
